// File: rtl/traffic_light_monitor_pkg.sv
// Shared definitions for the traffic light monitor: phase encodings,
// light bit positions and 7-segment digit patterns ({g,f,e,d,c,b,a}).
package traffic_mon_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_t;

    localparam int GREEN_BIT  = 0;
    localparam int YELLOW_BIT = 1;
    localparam int RED_BIT    = 2;

    localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;

    // Only the green->yellow->red->green ring counts as a legal hand-over.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_GREEN:  next_phase = PH_YELLOW;
            PH_YELLOW: next_phase = PH_RED;
            PH_RED:    next_phase = PH_GREEN;
            default:   next_phase = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_seg7_decoder.sv
// Combinational 7-segment pattern to BCD digit decoder; any pattern that
// is not one of the ten digit shapes is reported as invalid.
module seg7_decoder
    import traffic_mon_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (pattern)
            SEG_DIGIT_0: digit = 4'd0;
            SEG_DIGIT_1: digit = 4'd1;
            SEG_DIGIT_2: digit = 4'd2;
            SEG_DIGIT_3: digit = 4'd3;
            SEG_DIGIT_4: digit = 4'd4;
            SEG_DIGIT_5: digit = 4'd5;
            SEG_DIGIT_6: digit = 4'd6;
            SEG_DIGIT_7: digit = 4'd7;
            SEG_DIGIT_8: digit = 4'd8;
            SEG_DIGIT_9: digit = 4'd9;
            default:     valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light controller outputs: tracks phase
// order and timing, raises sticky errors. Define TRAFFIC_MON_SEG_CHECK_EN
// to also check the 7-segment display against the internal prescaler.
module traffic_light_monitor
    import traffic_mon_pkg::*;
#(
    parameter int pSECOND_CNT_VAL    = 99,
    parameter int pTIME_GREEN_LIGHT  = 15,
    parameter int pTIME_YELLOW_LIGHT = 3,
    parameter int pTIME_RED_LIGHT    = 18,
    parameter int pPHASE_CNT_WIDTH   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        green_light,
    input  logic                        yellow_light,
    input  logic                        red_light,
    input  logic [6:0]                  seg_a,
    input  logic [6:0]                  seg_b,
    output logic [1:0]                  phase,
    output logic [pPHASE_CNT_WIDTH-1:0] phase_secs,
    output logic                        phase_done,
    output logic                        err_onehot,
    output logic                        err_sequence,
    output logic                        err_duration,
    output logic                        err_segment
);

    localparam int PRESC_W = (pSECOND_CNT_VAL > 0) ? $clog2(pSECOND_CNT_VAL + 1) : 1;

    logic [PRESC_W-1:0]        prescaler;
    logic                      tick;
    logic [2:0]                lights;
    logic                      lights_onehot;
    phase_t                    state;
    phase_t                    seen_phase;
    logic                      checked;
    logic                      secs_full;
    logic [pPHASE_CNT_WIDTH:0] secs_plus_tick;
    logic [31:0]               required_secs;
    logic                      dur_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (en) begin
            if (prescaler == PRESC_W'(pSECOND_CNT_VAL))
                prescaler <= '0;
            else
                prescaler <= prescaler + PRESC_W'(1);
        end
    end

    assign tick = en && (prescaler == PRESC_W'(pSECOND_CNT_VAL));

    assign lights[GREEN_BIT]  = green_light;
    assign lights[YELLOW_BIT] = yellow_light;
    assign lights[RED_BIT]    = red_light;
    assign lights_onehot      = $onehot(lights);

    always_comb begin
        seen_phase = PH_IDLE;
        if (lights_onehot) begin
            if (lights[GREEN_BIT])       seen_phase = PH_GREEN;
            else if (lights[YELLOW_BIT]) seen_phase = PH_YELLOW;
            else                         seen_phase = PH_RED;
        end
    end

    // A tick landing in the hand-over cycle still belongs to the finished phase.
    assign secs_full      = &phase_secs;
    assign secs_plus_tick = {1'b0, phase_secs} + {{pPHASE_CNT_WIDTH{1'b0}}, tick};

    always_comb begin
        required_secs = 32'd0;
        case (state)
            PH_GREEN:  required_secs = 32'(pTIME_GREEN_LIGHT);
            PH_YELLOW: required_secs = 32'(pTIME_YELLOW_LIGHT);
            PH_RED:    required_secs = 32'(pTIME_RED_LIGHT);
            default:   required_secs = 32'd0;
        endcase
    end

    assign dur_mismatch = (32'(secs_plus_tick) != required_secs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= PH_IDLE;
            phase_secs   <= '0;
            phase_done   <= 1'b0;
            checked      <= 1'b0;
            err_onehot   <= 1'b0;
            err_sequence <= 1'b0;
            err_duration <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            if (state == PH_IDLE) begin
                if (lights_onehot) begin
                    state      <= seen_phase;
                    phase_secs <= '0;
                    checked    <= 1'b0;
                end else if (lights != 3'b000) begin
                    err_onehot <= 1'b1;
                end
            end else if (!lights_onehot) begin
                err_onehot <= 1'b1;
                if (tick && !secs_full)
                    phase_secs <= phase_secs + pPHASE_CNT_WIDTH'(1);
            end else if (seen_phase == state) begin
                if (tick && !secs_full)
                    phase_secs <= phase_secs + pPHASE_CNT_WIDTH'(1);
            end else if (seen_phase == next_phase(state)) begin
                state      <= seen_phase;
                phase_secs <= '0;
                phase_done <= 1'b1;
                checked    <= 1'b1;
                if (checked && dur_mismatch)
                    err_duration <= 1'b1;
            end else begin
                // Follow the observed light so later phases are judged afresh.
                state        <= seen_phase;
                phase_secs   <= '0;
                checked      <= 1'b0;
                err_sequence <= 1'b1;
            end
        end
    end

    assign phase = state;

`ifdef TRAFFIC_MON_SEG_CHECK_EN
    logic [3:0]         tens_digit;
    logic [3:0]         units_digit;
    logic               tens_valid;
    logic               units_valid;
    logic [PRESC_W-1:0] prev_prescaler;
    logic               seg_armed;

    seg7_decoder u_tens_decoder (
        .pattern (seg_a),
        .digit   (tens_digit),
        .valid   (tens_valid)
    );

    seg7_decoder u_units_decoder (
        .pattern (seg_b),
        .digit   (units_digit),
        .valid   (units_valid)
    );

    // The controller display lags its prescaler by one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_prescaler <= '0;
            seg_armed      <= 1'b0;
            err_segment    <= 1'b0;
        end else begin
            prev_prescaler <= prescaler;
            seg_armed      <= 1'b1;
            if (seg_armed && (!tens_valid || !units_valid ||
                (32'(tens_digit) * 32'd10 + 32'(units_digit) != 32'(prev_prescaler))))
                err_segment <= 1'b1;
        end
    end
`else
    logic unused_seg;
    assign unused_seg  = ^{seg_a, seg_b};
    assign err_segment = 1'b0;
`endif

endmodule
